dec_exp_pipe: RTL
=================

Name: dec_exp_pipe

Overview:
- Two-stage pipelined biased-exponent unit for the decimal floating-point multiplier/divider datapath.
- Computes the result exponent: E1+E2-BIAS for multiply, E1-E2+BIAS for divide, plus a signed normalisation adjustment.
- Flags overflow/underflow against the format range; valid/ready handshake on both sides so it can sit between the operand-unpack and coefficient-normalise stages.

Parameters:
EXP_W, 8, biased exponent width
BIAS, 101, exponent bias (decimal32 default)
EMAX, 191, largest legal biased exponent
ADJ_W, 4, width of signed normalisation adjustment (two's complement)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  unit can accept operands this cycle
op  input  1  0 = multiply, 1 = divide
e1  input  EXP_W  first biased exponent (unsigned)
e2  input  EXP_W  second biased exponent (unsigned)
adj  input  ADJ_W  signed normalisation shift, added to result
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
er  output  EXP_W  result biased exponent
overflow  output  1  true result > EMAX
underflow  output  1  true result < 0

Behaviour:
- Clock/reset: one clock (clk); rst synchronous, active-high. While rst is high, both stage valids clear and er/overflow/underflow are driven 0. in_ready = 1 in the first cycle after rst is released. Any in-flight data is discarded on reset.
- Transfer rules: input transfer on in_valid && in_ready; output transfer on out_valid && out_ready. Inputs are sampled only on a transfer.
- Stage 1 (registered):
  - Internal signed width W = EXP_W+ADJ_W+2; all operands zero-extended (e1, e2) or sign-extended (adj) to W. No intermediate truncation.
  - raw = op ? (e1 - e2 + BIAS) : (e1 + e2 - BIAS). raw and adj are registered.
- Stage 2 (registered, drives outputs):
  - res = raw + adj.
  - underflow = res < 0.
  - overflow = res > EMAX (signed compare).
  - Default er = res[EXP_W-1:0] (wrap).
  - overflow and underflow are mutually exclusive.
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 result per cycle.
- Stage advance and backpressure:
  - s2 loads when s2 is empty or s2 transfers this cycle.
  - s1 loads when s1 is empty or s1 advances this cycle.
  - in_ready = !s1_valid || s2_can_load (combinational from out_ready).
  - Full pipe with out_ready low: in_ready = 0, contents held stable.
- Ordering: results leave strictly in input order. No drop, no duplicate.
- Simultaneous events: input transfer and output transfer in the same cycle on a full pipe advance all stages with no bubble.
- Outputs er/overflow/underflow are stable while out_valid && !out_ready.
- Boundaries: res == 0 and res == EMAX are legal (no flag). e1 = e2 = 0 with op = 0 underflows. e1 = 2^EXP_W-1 with op = 1 and e2 = 0 overflows for the default parameters.

Optional Feature:
- Macro DEC_EXP_PIPE_SAT_EN.
- Defined: on underflow er = 0; on overflow er = EMAX. Flags unchanged.
- Undefined: er = low EXP_W bits of res (wrap), flags unchanged.

Decomposition:
- Shared package dec_fp_pkg holds:
  - format constants DEC32_EXP_W = 8, DEC32_BIAS = 101, DEC32_EMAX = 191;
  - op encoding constants OP_MUL = 0, OP_DIV = 1;
  - typedef for the stage payload struct {raw, adj, op}.
- One sub-module is natural: dec_pipe_reg, a generic valid/ready pipeline register with data width parameter, instantiated twice. The arithmetic stays in the top.

Test Plan:
- Multiply, e1=101, e2=101, adj=0, out_ready=1 -> er=101, no flags, out_valid exactly 2 cycles after the input transfer.
- Multiply, e1=50, e2=40, adj=0 -> underflow=1. er=245 without SAT_EN; er=0 with SAT_EN.
- Multiply, e1=150, e2=150, adj=-2 -> res=197, overflow=1. er=197 without SAT_EN; er=191 with SAT_EN.
- Divide, e1=120, e2=30, adj=+3 -> er=194, overflow. Then divide e1=30, e2=120, adj=0 -> er=11, no flags. Then multiply e1=95, e2=197, adj=0 -> er=191, no flags.
- Backpressure: stream 6 operand sets with out_ready=0 for 5 cycles, then 1 -> in_ready falls after 2 accepted, all 6 results emerge in order, outputs stable during the stall.
- Reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0, er/flags=0. First post-reset input appears after 2 cycles, uncorrupted.

Source files
------------

// File: rtl/dec_fp_pkg.sv
// Shared definitions for the decimal floating-point multiply/divide datapath.
//
// Contents:
//   - decimal32 exponent format constants (width, bias, largest biased exponent)
//   - operation encoding (multiply / divide)
//   - stage payload struct carried from the exponent add stage to the
//     adjust/range-check stage
//
// The payload fields are sized generously (32-bit raw, 16-bit adjustment).
// The exponent unit computes at its own internal width and sign-extends
// into these fields, so any EXP_W + ADJ_W + 2 <= 32 with ADJ_W <= 16 is
// carried without loss.
package dec_fp_pkg;

    localparam int DEC32_EXP_W = 8;
    localparam int DEC32_BIAS  = 101;
    localparam int DEC32_EMAX  = 191;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int PAY_RAW_W = 32;
    localparam int PAY_ADJ_W = 16;

    typedef struct packed {
        logic signed [PAY_RAW_W-1:0] raw;
        logic signed [PAY_ADJ_W-1:0] adj;
        logic                        op;
    } stage_t;

endpackage

// File: rtl/dec_pipe_reg.sv
// Generic valid/ready pipeline register (one entry).
//
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high on the same side. Data is captured only on an input transfer and held
// unchanged while out_valid && !out_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready = empty or draining)
//   in_data  [DW]         upstream payload
//   out_valid / out_ready downstream handshake
//   out_data [DW]         registered payload (cleared by reset)
module dec_pipe_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Accept when empty, or when the current entry leaves this same cycle.
    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/dec_exp_pipe.sv
// Two-stage pipelined biased-exponent unit for the decimal FP mul/div path.
//
// Stage 1: raw = op ? (e1 - e2 + BIAS) : (e1 + e2 - BIAS), registered with adj.
// Stage 2: res = raw + adj, range-checked against [0, EMAX], registered.
//
// Handshake: input transfer on in_valid && in_ready, output transfer on
// out_valid && out_ready. in_ready is combinational from out_ready through
// both stages, so a full pipe streams one result per cycle with no bubble.
//
// Configuration macro: DEC_EXP_PIPE_SAT_EN
//   defined   -> er clamps to 0 on underflow and to EMAX on overflow
//   undefined -> er is the low EXP_W bits of res (wrap)
//   Flags are identical in both builds.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake
//   op                   0 = multiply, 1 = divide
//   e1, e2 [EXP_W]       unsigned biased exponents
//   adj [ADJ_W]          signed normalisation adjustment
//   out_valid, out_ready result handshake
//   er [EXP_W]           result biased exponent
//   overflow, underflow  result above EMAX / below 0
module dec_exp_pipe
    import dec_fp_pkg::*;
#(
    parameter int EXP_W = DEC32_EXP_W,
    parameter int BIAS  = DEC32_BIAS,
    parameter int EMAX  = DEC32_EMAX,
    parameter int ADJ_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [EXP_W-1:0] e1,
    input  logic [EXP_W-1:0] e2,
    input  logic [ADJ_W-1:0] adj,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] er,
    output logic             overflow,
    output logic             underflow
);

    // Internal width wide enough that e1 + e2 + BIAS + adj never wraps.
    localparam int W    = EXP_W + ADJ_W + 2;
    localparam int S2_W = EXP_W + 2;

    // ---------------- stage 1: biased add / subtract ----------------
    logic signed [W-1:0] e1_w;
    logic signed [W-1:0] e2_w;
    logic signed [W-1:0] raw_w;
    stage_t              pay_in;

    always_comb begin
        e1_w   = W'(e1);
        e2_w   = W'(e2);
        raw_w  = (op == OP_DIV) ? (e1_w - e2_w + W'(BIAS))
                                : (e1_w + e2_w - W'(BIAS));
        pay_in        = '0;
        pay_in.raw    = PAY_RAW_W'(raw_w);
        pay_in.adj    = PAY_ADJ_W'($signed(adj));
        pay_in.op     = op;
    end

    logic   s1_valid;
    logic   s2_in_ready;
    stage_t s1_q;

    dec_pipe_reg #(
        .DW($bits(stage_t))
    ) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(s1_valid),
        .out_ready(s2_in_ready),
        .out_data (s1_q)
    );

    // The operation code rides along in the payload for observability of
    // stage 1; stage 2 arithmetic does not depend on it.
    logic unused_s1_op;
    assign unused_s1_op = s1_q.op;

    // ---------------- stage 2: adjust and range check ----------------
    logic signed [PAY_RAW_W-1:0] res;
    logic                        ov_n;
    logic                        uf_n;
    logic [EXP_W-1:0]            er_n;
    logic [S2_W-1:0]             s2_in;

    always_comb begin
        res  = s1_q.raw + PAY_RAW_W'(s1_q.adj);
        uf_n = (res < 0);
        ov_n = (res > EMAX);
`ifdef DEC_EXP_PIPE_SAT_EN
        if (uf_n) begin
            er_n = '0;
        end else if (ov_n) begin
            er_n = EXP_W'(EMAX);
        end else begin
            er_n = res[EXP_W-1:0];
        end
`else
        er_n = res[EXP_W-1:0];
`endif
        s2_in = {er_n, ov_n, uf_n};
    end

    logic            s2_valid;
    logic [S2_W-1:0] s2_q;

    dec_pipe_reg #(
        .DW(S2_W)
    ) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s1_valid),
        .in_ready (s2_in_ready),
        .in_data  (s2_in),
        .out_valid(s2_valid),
        .out_ready(out_ready),
        .out_data (s2_q)
    );

    // Outputs read as zero for the whole time reset is asserted, not only
    // after the first reset edge.
    always_comb begin
        out_valid = s2_valid && !rst;
        er        = rst ? '0 : s2_q[S2_W-1:2];
        overflow  = rst ? 1'b0 : s2_q[1];
        underflow = rst ? 1'b0 : s2_q[0];
    end

endmodule
